// File: rtl/mastermind_pkg.sv
// mastermind_pkg: shared definitions for the Mastermind scoring engine.
//   state_e     : FSM state encoding
//   sw_of/gw_of : widths of score counters and guess counter
//   peg()       : extract peg i (cw bits wide) from a packed code vector
package mastermind_pkg;

  typedef enum logic [2:0] {
    NO_CODE    = 3'd0,
    WAIT_GUESS = 3'd1,
    COUNT      = 3'd2,
    SUM        = 3'd3,
    GAME_OVER  = 3'd4
  } state_e;

  localparam int MAX_COLOR_W = 4;
  localparam int PEG_VEC_W   = 256;

  function automatic int sw_of(input int pegs);
    return $clog2(pegs + 1);
  endfunction

  function automatic int gw_of(input int max_guesses);
    return $clog2(max_guesses + 1);
  endfunction

  // Returns the peg zero-extended to MAX_COLOR_W bits.
  function automatic logic [MAX_COLOR_W-1:0] peg(input logic [PEG_VEC_W-1:0] vec,
                                                  input int unsigned          i,
                                                  input int unsigned          cw);
    logic [PEG_VEC_W-1:0]   sh;
    logic [MAX_COLOR_W-1:0] mask;
    sh   = vec >> (i * cw);
    mask = MAX_COLOR_W'((32'd1 << cw) - 32'd1);
    return sh[MAX_COLOR_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/mastermind_color_hist.sv
// mastermind_color_hist: NCOL colour bins of SW bits each.
//   clk, resetn : clock, async active-low reset (clears all bins)
//   i_clr       : synchronous clear of all bins (priority over increment)
//   i_inc       : increment bin i_inc_idx
//   i_rd_idx    : combinational read index, o_rd_data = bin[i_rd_idx]
module mastermind_color_hist #(
  parameter int NCOL = 8,
  parameter int SW   = 3,
  parameter int IDXW = 3
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            i_clr,
  input  logic            i_inc,
  input  logic [IDXW-1:0] i_inc_idx,
  input  logic [IDXW-1:0] i_rd_idx,
  output logic [SW-1:0]   o_rd_data
);

  logic [SW-1:0] r_bin [NCOL];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < NCOL; k++) r_bin[k] <= '0;
    end else if (i_clr) begin
      for (int k = 0; k < NCOL; k++) r_bin[k] <= '0;
    end else if (i_inc) begin
      r_bin[i_inc_idx] <= r_bin[i_inc_idx] + SW'(1);
    end
  end

  assign o_rd_data = r_bin[i_rd_idx];

endmodule

// File: rtl/mastermind_scorer.sv
// mastermind_scorer: Mastermind game engine. Latches a secret code, then
// scores each guess with a PEGS-cycle histogram pass followed by an
// NCOL-cycle min-sum pass, tracking guess count and win/lose.
//   code_valid/code    : start a new game (ignored while scoring)
//   guess_valid/ready  : guess handshake
//   score_valid        : one-cycle pulse when red/white/guess_num/win/lose update
//   dbg_state          : current FSM state
// Handshake: a guess transfers on a rising edge where guess_valid && guess_ready;
// guess_ready is only high in WAIT_GUESS with no code load offered, so a
// simultaneous code load always takes priority over the guess.
module mastermind_scorer
  import mastermind_pkg::*;
#(
  parameter int PEGS        = 4,
  parameter int COLOR_W     = 3,
  parameter int MAX_GUESSES = 8,
  localparam int SW = sw_of(PEGS),
  localparam int GW = gw_of(MAX_GUESSES)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    code_valid,
  input  logic [PEGS*COLOR_W-1:0] code,
  input  logic                    guess_valid,
  output logic                    guess_ready,
  input  logic [PEGS*COLOR_W-1:0] guess,
  output logic                    score_valid,
  output logic [SW-1:0]           red,
  output logic [SW-1:0]           white,
  output logic [GW-1:0]           guess_num,
  output logic                    win,
  output logic                    lose,
  output state_e                  dbg_state
);

  localparam int NCOL = 2 ** COLOR_W;
  localparam int W    = PEGS * COLOR_W;
  localparam int IW   = (PEGS > 1) ? $clog2(PEGS) : 1;

  state_e              r_state, w_next_state;
  logic [W-1:0]        r_code, r_guess;
  logic [IW-1:0]       r_peg_idx;
  logic [COLOR_W-1:0]  r_col_idx;
  logic [SW-1:0]       r_red_acc, r_match_acc;
  logic [SW-1:0]       r_red, r_white;
  logic [GW-1:0]       r_guess_num;
  logic                r_win, r_lose, r_score_valid;

  logic                   w_load_code, w_accept;
  logic [MAX_COLOR_W-1:0] w_code_peg, w_guess_peg;
  logic                   w_red_hit;
  logic [SW-1:0]          w_hc, w_hg, w_min, w_match_next;
  logic                   w_peg_last, w_col_last, w_win, w_lose;

  assign w_code_peg   = peg(PEG_VEC_W'(r_code),  32'(r_peg_idx), COLOR_W);
  assign w_guess_peg  = peg(PEG_VEC_W'(r_guess), 32'(r_peg_idx), COLOR_W);
  assign w_red_hit    = (w_code_peg == w_guess_peg);
  assign w_peg_last   = (r_peg_idx == IW'(PEGS - 1));
  assign w_col_last   = (r_col_idx == COLOR_W'(NCOL - 1));
  assign w_min        = (w_hc < w_hg) ? w_hc : w_hg;
  assign w_match_next = r_match_acc + w_min;
  assign w_win        = (r_red_acc == SW'(PEGS));
  assign w_lose       = !w_win && ((32'(r_guess_num) + 32'd1) == 32'(MAX_GUESSES));

  mastermind_color_hist #(.NCOL(NCOL), .SW(SW), .IDXW(COLOR_W)) u_hist_code (
    .clk       (clk),
    .resetn    (resetn),
    .i_clr     (w_accept),
    .i_inc     (r_state == COUNT),
    .i_inc_idx (w_code_peg[COLOR_W-1:0]),
    .i_rd_idx  (r_col_idx),
    .o_rd_data (w_hc)
  );

  mastermind_color_hist #(.NCOL(NCOL), .SW(SW), .IDXW(COLOR_W)) u_hist_guess (
    .clk       (clk),
    .resetn    (resetn),
    .i_clr     (w_accept),
    .i_inc     (r_state == COUNT),
    .i_inc_idx (w_guess_peg[COLOR_W-1:0]),
    .i_rd_idx  (r_col_idx),
    .o_rd_data (w_hg)
  );

  always_comb begin
    w_next_state = r_state;
    w_load_code  = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      NO_CODE, GAME_OVER: begin
        if (code_valid) begin
          w_load_code  = 1'b1;
          w_next_state = WAIT_GUESS;
        end
      end
      WAIT_GUESS: begin
        if (code_valid) begin
          w_load_code  = 1'b1;
        end else if (guess_valid) begin
          w_accept     = 1'b1;
          w_next_state = COUNT;
        end
      end
      COUNT: begin
        if (w_peg_last) w_next_state = SUM;
      end
      SUM: begin
        if (w_col_last) w_next_state = (w_win || w_lose) ? GAME_OVER : WAIT_GUESS;
      end
      default: w_next_state = NO_CODE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= NO_CODE;
      r_code        <= '0;
      r_guess       <= '0;
      r_peg_idx     <= '0;
      r_col_idx     <= '0;
      r_red_acc     <= '0;
      r_match_acc   <= '0;
      r_red         <= '0;
      r_white       <= '0;
      r_guess_num   <= '0;
      r_win         <= 1'b0;
      r_lose        <= 1'b0;
      r_score_valid <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_score_valid <= 1'b0;
      if (w_load_code) begin
        r_code      <= code;
        r_red       <= '0;
        r_white     <= '0;
        r_guess_num <= '0;
        r_win       <= 1'b0;
        r_lose      <= 1'b0;
      end
      if (w_accept) begin
        r_guess     <= guess;
        r_peg_idx   <= '0;
        r_col_idx   <= '0;
        r_red_acc   <= '0;
        r_match_acc <= '0;
      end
      if (r_state == COUNT) begin
        if (w_red_hit) r_red_acc <= r_red_acc + SW'(1);
        if (!w_peg_last) r_peg_idx <= r_peg_idx + IW'(1);
      end
      if (r_state == SUM) begin
        r_match_acc <= w_match_next;
        r_col_idx   <= r_col_idx + COLOR_W'(1);
        if (w_col_last) begin
          r_red         <= r_red_acc;
          // match count always covers the exact hits, so this cannot underflow
          r_white       <= w_match_next - r_red_acc;
          r_score_valid <= 1'b1;
          r_guess_num   <= r_guess_num + GW'(1);
          r_win         <= w_win;
          r_lose        <= w_lose;
        end
      end
    end
  end

  assign guess_ready = (r_state == WAIT_GUESS) && !code_valid;
  assign score_valid = r_score_valid;
  assign red         = r_red;
  assign white       = r_white;
  assign guess_num   = r_guess_num;
  assign win         = r_win;
  assign lose        = r_lose;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_mastermind_scorer.sv
// Bench for mastermind_scorer (default parameters: 4 pegs, 3-bit colours,
// 8 guesses). A cycle-level reference model tracks game mode and scores,
// a compare process checks all outputs every cycle, and directed tests pin
// hand-computed values.
module tb_mastermind_scorer;
  import mastermind_pkg::*;

  localparam int PEGS = 4;
  localparam int CW   = 3;
  localparam int MAXG = 8;
  localparam int NCOL = 8;
  localparam int W    = PEGS * CW;

  // clock / reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic         code_valid = 1'b0;
  logic [W-1:0] code = '0;
  logic         guess_valid = 1'b0;
  logic [W-1:0] guess = '0;
  logic         guess_ready, score_valid, win, lose;
  logic [2:0]   red, white;
  logic [3:0]   guess_num;
  state_e       dbg_state;

  mastermind_scorer #(.PEGS(PEGS), .COLOR_W(CW), .MAX_GUESSES(MAXG)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .code_valid  (code_valid),
    .code        (code),
    .guess_valid (guess_valid),
    .guess_ready (guess_ready),
    .guess       (guess),
    .score_valid (score_valid),
    .red         (red),
    .white       (white),
    .guess_num   (guess_num),
    .win         (win),
    .lose        (lose),
    .dbg_state   (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 60) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack4(input int a, input int b, input int c, input int d);
    return {d[2:0], c[2:0], b[2:0], a[2:0]};
  endfunction

  // Score from the game rules: exact hits, plus colour overlap minus hits.
  function automatic void model_score(input logic [W-1:0] c, input logic [W-1:0] g,
                                      output int r, output int w);
    int hc[NCOL];
    int hg[NCOL];
    int m;
    for (int k = 0; k < NCOL; k++) begin hc[k] = 0; hg[k] = 0; end
    r = 0;
    for (int i = 0; i < PEGS; i++) begin
      if (c[i*CW +: CW] == g[i*CW +: CW]) r++;
      hc[c[i*CW +: CW]]++;
      hg[g[i*CW +: CW]]++;
    end
    m = 0;
    for (int k = 0; k < NCOL; k++) m += (hc[k] < hg[k]) ? hc[k] : hg[k];
    w = m - r;
  endfunction

  // reference model: mode 0 no code, 1 waiting, 2 scoring, 3 game over
  int           m_mode = 0, m_cnt = 0;
  logic [W-1:0] m_code = '0, m_guess = '0;
  int           m_red = 0, m_white = 0, m_gnum = 0;
  bit           m_win = 0, m_lose = 0, m_sv = 0;

  initial forever begin
    int r, w;
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      m_mode = 0; m_cnt = 0; m_sv = 0;
      m_red = 0; m_white = 0; m_gnum = 0; m_win = 0; m_lose = 0;
    end else begin
      m_sv = 0;
      if (m_mode == 2) begin
        m_cnt--;
        if (m_cnt == 0) begin
          model_score(m_code, m_guess, r, w);
          m_red = r; m_white = w; m_gnum++;
          m_win  = (r == PEGS);
          m_lose = !m_win && (m_gnum == MAXG);
          m_sv   = 1;
          m_mode = (m_win || m_lose) ? 3 : 1;
        end
      end else if (code_valid) begin
        m_code = code; m_mode = 1;
        m_red = 0; m_white = 0; m_gnum = 0; m_win = 0; m_lose = 0;
      end else if (m_mode == 1 && guess_valid) begin
        m_guess = guess; m_cnt = PEGS + NCOL; m_mode = 2;
      end
    end
  end

  // compare process
  initial forever begin
    @(negedge clk);
    #1;
    chk("guess_ready", 32'(guess_ready), 32'(m_mode == 1 && !code_valid));
    chk("score_valid", 32'(score_valid), 32'(m_sv));
    chk("red",         32'(red),         32'(m_red));
    chk("white",       32'(white),       32'(m_white));
    chk("guess_num",   32'(guess_num),   32'(m_gnum));
    chk("win",         32'(win),         32'(m_win));
    chk("lose",        32'(lose),        32'(m_lose));
  end

  // driver tasks
  task automatic load_code(input logic [W-1:0] c);
    @(negedge clk);
    code = c; code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0; code = W'($urandom);
  endtask

  task automatic send_guess(input logic [W-1:0] g);
    int n;
    @(negedge clk);
    guess = g; guess_valid = 1'b1;
    #1;
    n = 0;
    while (!guess_ready && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 100) chk("guess_accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    guess_valid = 1'b0; guess = W'($urandom);
  endtask

  task automatic wait_score(output int n);
    n = 0;
    while (score_valid !== 1'b1 && n < 60) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 60) chk("score_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [W-1:0] rand_code();
    logic [W-1:0] v;
    bit narrow;
    narrow = ($urandom_range(0, 1) == 1);
    for (int i = 0; i < PEGS; i++)
      v[i*CW +: CW] = CW'(narrow ? $urandom_range(0, 3) : $urandom_range(0, 7));
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, w, n;

    // pin the model itself
    model_score(pack4(1, 1, 2, 3), pack4(1, 2, 1, 1), r, w);
    chk("model_red_1123", 32'(r), 32'd1);
    chk("model_white_1123", 32'(w), 32'd2);
    model_score(pack4(1, 1, 2, 2), pack4(2, 2, 1, 1), r, w);
    chk("model_white_1122", 32'(w), 32'd4);

    repeat (3) @(negedge clk);
    #1;
    chk("reset_state", 32'(dbg_state), 32'(NO_CODE));
    chk("reset_ready", 32'(guess_ready), 32'd0);
    #2 resetn = 1'b1;

    // 1122 vs 2211
    load_code(pack4(1, 1, 2, 2));
    send_guess(pack4(2, 2, 1, 1));
    wait_score(n);
    chk("lat_2211", 32'(n), 32'd12);
    chk("red_2211", 32'(red), 32'd0);
    chk("white_2211", 32'(white), 32'd4);
    chk("win_2211", 32'(win), 32'd0);

    // reset in the middle of COUNT
    send_guess(pack4(1, 2, 3, 4));
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("rst_white", 32'(white), 32'd0);
    chk("rst_gnum", 32'(guess_num), 32'd0);
    chk("rst_sv", 32'(score_valid), 32'd0);
    chk("rst_ready", 32'(guess_ready), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(NO_CODE));
    @(negedge clk);
    #2 resetn = 1'b1;
    repeat (15) @(negedge clk);

    load_code(pack4(5, 5, 5, 5));
    send_guess(pack4(5, 5, 5, 5));
    wait_score(n);
    chk("red_5555", 32'(red), 32'd4);
    chk("win_5555", 32'(win), 32'd1);

    // 1234 win
    load_code(pack4(1, 2, 3, 4));
    send_guess(pack4(1, 2, 3, 4));
    wait_score(n);
    chk("lat_1234", 32'(n), 32'd12);
    chk("red_1234", 32'(red), 32'd4);
    chk("white_1234", 32'(white), 32'd0);
    chk("gnum_1234", 32'(guess_num), 32'd1);
    chk("win_1234", 32'(win), 32'd1);
    @(negedge clk);
    guess_valid = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("ready_after_win", 32'(guess_ready), 32'd0);
    guess_valid = 1'b0;

    // 1123 vs 1211, then 0000 vs 7777
    load_code(pack4(1, 1, 2, 3));
    send_guess(pack4(1, 2, 1, 1));
    wait_score(n);
    chk("red_1211", 32'(red), 32'd1);
    chk("white_1211", 32'(white), 32'd2);
    load_code(pack4(0, 0, 0, 0));
    send_guess(pack4(7, 7, 7, 7));
    wait_score(n);
    chk("red_7777", 32'(red), 32'd0);
    chk("white_7777", 32'(white), 32'd0);

    // lose after eight guesses
    load_code(pack4(0, 1, 2, 3));
    for (int k = 1; k <= MAXG; k++) begin
      send_guess(pack4(7, 7, 7, 7));
      wait_score(n);
      chk("lose_gnum", 32'(guess_num), 32'(k));
      chk("lose_flag", 32'(lose), 32'(k == MAXG));
    end
    @(negedge clk);
    guess_valid = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("ninth_gnum", 32'(guess_num), 32'd8);
    load_code(pack4(0, 1, 2, 3));
    guess_valid = 1'b0;
    #1;
    chk("reload_lose", 32'(lose), 32'd0);
    chk("reload_gnum", 32'(guess_num), 32'd0);

    // code and guess offered together in WAIT_GUESS
    @(negedge clk);
    code = pack4(3, 3, 3, 3); code_valid = 1'b1;
    guess = pack4(3, 3, 3, 3); guess_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0; guess_valid = 1'b0;
    #1;
    chk("both_gnum", 32'(guess_num), 32'd0);
    chk("both_state", 32'(dbg_state), 32'(WAIT_GUESS));

    // randomized games
    for (int gm = 0; gm < 40; gm++) begin
      load_code(rand_code());
      for (int k = 0; k < 6; k++) begin
        if (m_mode == 3) break;
        send_guess(rand_code());
        if ($urandom_range(0, 3) == 0) begin
          code = rand_code(); code_valid = 1'b1;
          @(negedge clk);
          code_valid = 1'b0;
        end
        wait_score(n);
      end
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
